atm_journal_reader: RTL
=======================

Name: atm_journal_reader

Overview:
- Drains the ATM controller's transaction log to an external host.
- Accepts one log entry per cycle from the ATM side: card id, transaction type and amount.
- Buffers entries in a circular FIFO and serialises each one as a 5-byte frame on a byte-wide valid/ready stream.
- Sits between the ATM FSM's logging path and the host/audit uplink; it is the reader for the ATM's journal writer.

Parameters:
DEPTH, 16, FIFO entries (power of two)
ADDR_W, 4, log2(DEPTH)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
log_valid  in  1  ATM presents a log entry this cycle
log_card  in  4  card number low nibble
log_type  in  4  transaction type (1 balance, 2 withdrawal, 3 deposit, 4 pin change)
log_amount  in  16  transaction amount
log_ready  out  1  FIFO not full (combinational from registered count)
out_data  out  8  frame byte
out_valid  out  1  out_data valid
out_ready  in  1  host accepts byte
out_last  out  1  high with the checksum byte
level  out  ADDR_W+1  entries held in FIFO, excluding the frame in flight
overflow  out  1  sticky: an entry was dropped
drop_count  out  8  dropped entries, saturates at 255
clear_overflow  in  1  clears overflow and drop_count

Behaviour:
- Reset (async, asynchronous assertion): FIFO empty, level=0, out_valid=0, out_last=0, out_data=0, overflow=0, drop_count=0, FSM=IDLE.
- Reset mid-frame: the partial frame is abandoned and never resumed.
- FIFO entry: 24 bits {card, type, amount}.
- Push: occurs when log_valid && log_ready.
  - If log_valid && !log_ready: the entry is dropped, overflow<=1, drop_count increments (saturating).
  - A pop in the same cycle does not rescue an entry arriving while full; it is still dropped.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves level unchanged.
- FSM states:
  - IDLE: if level!=0, pop the head into the frame register (hdr={card,type}, amt), compute csum=hdr^amt[15:8]^amt[7:0], go to SYNC.
  - SYNC: out_data=SYNC_BYTE.
  - HDR: out_data=hdr.
  - AMT_HI: out_data=amt[15:8].
  - AMT_LO: out_data=amt[7:0].
  - CSUM: out_data=csum, out_last=1.
- In every byte state out_valid=1. The state advances only on out_valid && out_ready.
  - CSUM accept -> IDLE. This gives one idle cycle between frames.
- Stream rules: once out_valid is asserted, out_data and out_last hold stable until accepted. out_valid never drops without acceptance, except on reset.
- Latency:
  - Entry pushed at edge E with FIFO empty and FSM idle: the popping edge is E+1, and out_valid=1 with SYNC_BYTE in the cycle after E+1.
  - With out_ready held high, a frame takes 5 cycles plus 1 idle cycle, so sustained throughput is 1 entry per 6 cycles.
- clear_overflow: at the next edge, overflow<=0 and drop_count<=0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- level is a registered count, updated the edge after push/pop.

Test Plan:
- Single entry card=1, type=2, amount=16'h0064, out_ready=1 -> bytes A5, 12, 00, 64, 76; out_last only on 76; out_valid first high 2 edges after push; level 1->0.
- Backpressure: out_ready=0 for 4 cycles during HDR -> out_data holds 12 and out_valid stays 1; the frame resumes correctly when out_ready returns high.
- Fill: push 17 entries back-to-back with out_ready=0 -> first entry popped into frame register, level reaches 16, log_ready=0. The 18th push -> overflow=1, drop_count=1. Drain -> 17 frames in push order, with payloads matching.
- Wrap: 40 pushes interleaved with draining -> pointer wrap, all frames in order, level returns to 0, overflow stays 0.
- Clear collision: while full, assert clear_overflow and log_valid in the same cycle -> overflow=1, drop_count=1. A later clear alone -> both 0.
- Reset mid-frame during AMT_HI -> out_valid=0 immediately, level=0. After release with no new pushes, out_valid stays 0.

Source files
------------

// File: rtl/atm_journal_reader.sv
// ATM journal reader: buffers {card,type,amount} log entries in a circular FIFO
// and streams each one to the host as a 5-byte frame (sync, hdr, amt_hi, amt_lo, csum).
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | no frame in flight; pops head when FIFO non-empty
// S_SYNC   | presenting SYNC_BYTE
// S_HDR    | presenting {card,type}
// S_AMT_HI | presenting amount[15:8]
// S_AMT_LO | presenting amount[7:0]
// S_CSUM   | presenting checksum, out_last high
module atm_journal_reader #(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              log_valid,
    input  logic [3:0]        log_card,
    input  logic [3:0]        log_type,
    input  logic [15:0]       log_amount,
    output logic              log_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [7:0]        drop_count,
    input  logic              clear_overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_HDR, S_AMT_HI, S_AMT_LO, S_CSUM
    } state_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    state_t              state_q, state_d;
    logic [23:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]     count_q, count_d;
    logic [7:0]          hdr_q, csum_q;
    logic [15:0]         amt_q;
    logic                overflow_q;
    logic [7:0]          drop_count_q;
    logic [23:0]         head;
    logic                push, pop, drop;

    assign log_ready  = (count_q != FULL);
    assign push       = log_valid && log_ready;
    assign drop       = log_valid && !log_ready;
    assign head       = mem_q[rd_ptr_q];
    assign level      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        out_valid = 1'b1;
        out_data  = 8'h00;
        out_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                out_valid = 1'b0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_SYNC;
                end
            end
            S_SYNC: begin
                out_data = SYNC_BYTE;
                if (out_ready) state_d = S_HDR;
            end
            S_HDR: begin
                out_data = hdr_q;
                if (out_ready) state_d = S_AMT_HI;
            end
            S_AMT_HI: begin
                out_data = amt_q[15:8];
                if (out_ready) state_d = S_AMT_LO;
            end
            S_AMT_LO: begin
                out_data = amt_q[7:0];
                if (out_ready) state_d = S_CSUM;
            end
            S_CSUM: begin
                out_data = csum_q;
                out_last = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: begin
                out_valid = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {log_card, log_type, log_amount};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hdr_q    <= '0;
            amt_q    <= '0;
            csum_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                hdr_q    <= head[23:16];
                amt_q    <= head[15:0];
                csum_q   <= head[23:16] ^ head[15:8] ^ head[7:0];
            end
        end
    end

    // A drop in the same cycle as a clear wins, restarting the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clear_overflow)
                drop_count_q <= 8'd1;
            else if (drop_count_q != 8'hFF)
                drop_count_q <= drop_count_q + 8'd1;
        end else if (clear_overflow) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end
    end

endmodule
